// File: rtl/rgb_pwm_sequencer.sv
// Colour-cycling breathing PWM generator for the RGB LED driver primitive.
// Red, green and blue in turn fade up, hold at full brightness, then fade down.
module rgb_pwm_sequencer #(
    parameter int PWM_BITS     = 8,
    parameter int PRESCALE     = 1024,
    parameter int STEP_PERIODS = 1,
    parameter int HOLD_STEPS   = 64
) (
    input  logic       hw_clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic       pwm_red,
    output logic       pwm_green,
    output logic       pwm_blue,
    output logic [1:0] colour_idx,
    output logic       cycle_done
);

    localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int STEP_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam int HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_PERIODS - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);
    localparam logic [PWM_BITS-1:0] LVL_MAX   = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] LVL_ZERO  = '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FADE_UP,
        ST_HOLD,
        ST_FADE_DOWN
    } state_e;

    state_e              state_q,    state_d;
    logic [PRE_W-1:0]    pre_cnt_q,  pre_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q,  pwm_cnt_d;
    logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [PWM_BITS-1:0] level_q,    level_d;
    logic [PWM_BITS-1:0] shadow_q,   shadow_d;
    logic [1:0]          colour_q,   colour_d;
    logic [2:0]          pwm_q,      pwm_d;
    logic                done_q,     done_d;

    logic tick;
    logic period_end;
    logic step;
    logic pwm_on;

    function automatic logic [PWM_BITS-1:0] level_inc(input logic [PWM_BITS-1:0] lvl);
        return (lvl == LVL_MAX) ? lvl : lvl + PWM_BITS'(1);
    endfunction

    function automatic logic [PWM_BITS-1:0] level_dec(input logic [PWM_BITS-1:0] lvl);
        return (lvl == LVL_ZERO) ? lvl : lvl - PWM_BITS'(1);
    endfunction

    function automatic logic [1:0] colour_next(input logic [1:0] col);
        return (col == 2'd2) ? 2'd0 : col + 2'd1;
    endfunction

    always_comb begin
        tick       = (pre_cnt_q == PRE_LAST);
        period_end = tick && (pwm_cnt_q == LVL_MAX);
        step       = period_end && (step_cnt_q == STEP_LAST);

        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        pwm_cnt_d  = pwm_cnt_q;
        step_cnt_d = step_cnt_q;
        hold_cnt_d = hold_cnt_q;
        level_d    = level_q;
        shadow_d   = shadow_q;
        colour_d   = colour_q;
        done_d     = 1'b0;
        pwm_d      = 3'b000;
        pwm_on     = 1'b0;

        if (!enable) begin
            state_d    = ST_IDLE;
            pre_cnt_d  = '0;
            pwm_cnt_d  = '0;
            step_cnt_d = '0;
            hold_cnt_d = '0;
            level_d    = '0;
            shadow_d   = '0;
            colour_d   = 2'd0;
        end else begin
            pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
            if (tick) begin
                pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
            end
            if (period_end) begin
                step_cnt_d = step ? '0 : step_cnt_q + STEP_W'(1);
            end

            unique case (state_q)
                ST_IDLE: begin
                    state_d    = ST_FADE_UP;
                    level_d    = '0;
                    colour_d   = 2'd0;
                    hold_cnt_d = '0;
                end
                ST_FADE_UP: begin
                    if (step) begin
                        level_d = level_inc(level_q);
                        if (level_d == LVL_MAX) begin
                            state_d    = ST_HOLD;
                            hold_cnt_d = '0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (step) begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            state_d    = ST_FADE_DOWN;
                            hold_cnt_d = '0;
                        end else begin
                            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                        end
                    end
                end
                ST_FADE_DOWN: begin
                    if (step) begin
                        level_d = level_dec(level_q);
                        if (level_d == LVL_ZERO) begin
                            colour_d = colour_next(colour_q);
                            done_d   = (colour_q == 2'd2);
                            state_d  = ST_FADE_UP;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // Shadow only reloads at the wrap, so a level change never cuts a period short.
            if (period_end) begin
                shadow_d = level_d;
            end

            pwm_on = (pwm_cnt_d < shadow_d);
            case (colour_d)
                2'd0:    pwm_d[0] = pwm_on;
                2'd1:    pwm_d[1] = pwm_on;
                2'd2:    pwm_d[2] = pwm_on;
                default: pwm_d    = 3'b000;
            endcase
        end
    end

    always_ff @(posedge hw_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pre_cnt_q  <= '0;
            pwm_cnt_q  <= '0;
            step_cnt_q <= '0;
            hold_cnt_q <= '0;
            level_q    <= '0;
            shadow_q   <= '0;
            colour_q   <= 2'd0;
            pwm_q      <= 3'b000;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            step_cnt_q <= step_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            level_q    <= level_d;
            shadow_q   <= shadow_d;
            colour_q   <= colour_d;
            pwm_q      <= pwm_d;
            done_q     <= done_d;
        end
    end

    assign pwm_red    = pwm_q[0];
    assign pwm_green  = pwm_q[1];
    assign pwm_blue   = pwm_q[2];
    assign colour_idx = colour_q;
    assign cycle_done = done_q;

endmodule
